// File: rtl/trig_param_bank.sv
// -----------------------------------------------------------------------------
// trig_param_bank
//   A bank of NCH runtime parameter words (gains, damping coefficients, clock
//   divider counts, float bit patterns). The USB host loads them through
//   one-cycle trigger pulses and a shared data word. The bank supports
//   restore-to-defaults, per-channel update strobes and a registered readback
//   port. When TPB_STAGED_EN is defined, it also supports staged writes with an
//   atomic commit.
//
//   Build option:
//     TPB_STAGED_EN  defined   -> a write goes to a shadow register and raises
//                                 pending[i]. A COMMIT_BIT pulse copies every
//                                 pending shadow into the active registers.
//                    undefined -> a write goes straight to the active register.
//                                 No shadow registers are built, pending is
//                                 tied to 0 and COMMIT_BIT is ignored.
//
//   Ports:
//     sim_clk       in   clock; all state updates on the rising edge
//     reset_global  in   asynchronous, active-high reset
//     trig          in   [TRIG_W-1:0] one-cycle trigger pulses (sim_clk domain)
//     wr_data       in   [W-1:0] write data, sampled while a trigger is high
//     rd_sel        in   [7:0] readback channel select
//     param_flat    out  [NCH*W-1:0] active values; channel i at [i*W +: W]
//     updated       out  [NCH-1:0] one-cycle strobe per channel loaded this cycle
//     pending       out  [NCH-1:0] channel holds a staged value not yet committed
//     rd_data       out  [W-1:0] registered active value of channel rd_sel
// -----------------------------------------------------------------------------
module trig_param_bank #(
  parameter int                  NCH         = 8,
  parameter int                  W           = 32,
  parameter int                  TRIG_W      = 16,
  parameter logic [NCH*4-1:0]    TRIG_MAP    = 32'h76543210,
  parameter int                  COMMIT_BIT  = 14,
  parameter int                  RESTORE_BIT = 15,
  parameter logic [NCH*W-1:0]    DEFAULTS    = {NCH*W{1'b0}}
) (
  input  logic                sim_clk,
  input  logic                reset_global,
  input  logic [TRIG_W-1:0]   trig,
  input  logic [W-1:0]        wr_data,
  input  logic [7:0]          rd_sel,
  output logic [NCH*W-1:0]    param_flat,
  output logic [NCH-1:0]      updated,
  output logic [NCH-1:0]      pending,
  output logic [W-1:0]        rd_data
);

  logic [NCH-1:0]   wr_hit;
  logic             restore;
  logic [NCH*W-1:0] active_q,  active_d;
  logic [NCH-1:0]   updated_q, updated_d;
  logic [W-1:0]     rd_data_q, rd_data_d;

  // Collects every trigger bit so that bits with no role still count as read.
  logic unused_trig_bits;
  assign unused_trig_bits = ^trig;

  // Decode the per-channel write triggers. A map entry that points past the
  // trigger bus never fires.
  for (genvar i = 0; i < NCH; i++) begin : g_hit
    localparam int IDX = int'(TRIG_MAP[i*4 +: 4]);
    if (IDX < TRIG_W) begin : g_in
      assign wr_hit[i] = trig[IDX];
    end else begin : g_out
      assign wr_hit[i] = 1'b0;
    end
  end

  assign restore = trig[RESTORE_BIT];

  // Readback mux. Its output is registered, so a load shows up here one cycle
  // after it is visible on param_flat.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == 8'(i)) rd_data_d = active_q[i*W +: W];
    end
  end

`ifdef TPB_STAGED_EN
  logic             commit;
  logic [NCH*W-1:0] shadow_q,  shadow_d;
  logic [NCH-1:0]   pending_q, pending_d;

  assign commit = trig[COMMIT_BIT];

  // Priority: restore over commit over plain writes. When a commit arrives
  // with a write in the same cycle, the fresh wr_data goes past the shadow
  // straight into active.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    updated_d = '0;
    if (restore) begin
      active_d  = DEFAULTS;
      shadow_d  = DEFAULTS;
      pending_d = '0;
      updated_d = '1;
    end else if (commit) begin
      pending_d = '0;
      for (int j = 0; j < NCH; j++) begin
        if (wr_hit[j]) begin
          shadow_d[j*W +: W] = wr_data;
          active_d[j*W +: W] = wr_data;
          updated_d[j]       = 1'b1;
        end else if (pending_q[j]) begin
          active_d[j*W +: W] = shadow_q[j*W +: W];
          updated_d[j]       = 1'b1;
        end
      end
    end else begin
      for (int j = 0; j < NCH; j++) begin
        if (wr_hit[j]) begin
          shadow_d[j*W +: W] = wr_data;
          pending_d[j]       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sim_clk or posedge reset_global) begin
    if (reset_global) begin
      shadow_q  <= DEFAULTS;
      pending_q <= '0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
`else
  // Direct mode: a write goes straight to active. Restore takes priority and
  // discards any write in the same cycle.
  always_comb begin
    active_d  = active_q;
    updated_d = '0;
    if (restore) begin
      active_d  = DEFAULTS;
      updated_d = '1;
    end else begin
      for (int j = 0; j < NCH; j++) begin
        if (wr_hit[j]) begin
          active_d[j*W +: W] = wr_data;
          updated_d[j]       = 1'b1;
        end
      end
    end
  end

  assign pending = '0;
`endif

  always_ff @(posedge sim_clk or posedge reset_global) begin
    if (reset_global) begin
      active_q  <= DEFAULTS;
      updated_q <= '0;
      rd_data_q <= '0;
    end else begin
      active_q  <= active_d;
      updated_q <= updated_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign param_flat = active_q;
  assign updated    = updated_q;
  assign rd_data    = rd_data_q;

endmodule
